// File: rtl/lsu_memory_responder_pkg.sv
// Shared LSU definitions: memory-op encoding and the pipeline-entry record.
// Entry payload widths are fixed here; the responder's XLEN/ROB_TAG_WIDTH must not exceed them.
package lsu_memory_responder_pkg;

    localparam int LSU_XLEN  = 32;
    localparam int LSU_TAG_W = 32;

    typedef enum logic {
        MEM_OP_LOAD  = 1'b0,
        MEM_OP_STORE = 1'b1
    } mem_op_e;

    typedef struct packed {
        logic                  valid;
        mem_op_e               op;
        logic [LSU_XLEN-1:0]   addr;
        logic [LSU_XLEN-1:0]   data;
        logic [LSU_TAG_W-1:0]  tag;
    } lsu_entry_t;

endpackage

// File: rtl/lsu_data_ram.sv
// Word-addressed data array: one shared address, synchronous write, combinational read.
// Deliberately has no reset so contents survive a core reset.
module lsu_data_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/lsu_memory_responder.sv
// Fixed-latency LSU memory model: requests ride a LATENCY-deep valid pipeline and complete from the last stage.
// Build option LSU_MEM_KILL_EN: kill_mem_req squashes the request accepted on the previous edge.
module lsu_memory_responder
    import lsu_memory_responder_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fire_memory_op,
    input  logic                     memory_op_type,
    input  logic [XLEN-1:0]          memory_address,
    input  logic [XLEN-1:0]          memory_data,
    input  logic [ROB_TAG_WIDTH-1:0] memory_rob_tag,
    input  logic                     kill_mem_req,
    output logic                     load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
    output logic                     store_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag,
    output logic                     cdb_active,
    output logic [XLEN-1:0]          cdb_data,
    output logic [ROB_TAG_WIDTH-1:0] cdb_tag,
    output logic [3:0]               inflight_count
);

    localparam int AW = $clog2(MEM_DEPTH);

    lsu_entry_t stage_q [1:LATENCY];
    lsu_entry_t stage_d [1:LATENCY];
    lsu_entry_t done;

    logic                     kill_en;
    logic                     is_load;
    logic                     is_store;
    logic [XLEN-1:0]          ram_rdata;
    logic [3:0]               inflight_d;

    logic                     ld_vld_q;
    logic                     st_vld_q;
    logic [ROB_TAG_WIDTH-1:0] ld_tag_q;
    logic [ROB_TAG_WIDTH-1:0] st_tag_q;
    logic [XLEN-1:0]          cdb_data_q;

`ifdef LSU_MEM_KILL_EN
    assign kill_en = kill_mem_req;
`else
    logic unused_kill;
    assign kill_en     = 1'b0;
    assign unused_kill = kill_mem_req;
`endif

    always_comb begin
        stage_d    = stage_q;
        stage_d[1] = '0;
        if (fire_memory_op) begin
            stage_d[1].valid = 1'b1;
            stage_d[1].op    = mem_op_e'(memory_op_type);
            stage_d[1].addr  = LSU_XLEN'(memory_address);
            stage_d[1].data  = LSU_XLEN'(memory_data);
            stage_d[1].tag   = LSU_TAG_W'(memory_rob_tag);
        end
        for (int i = 2; i <= LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        // Squash acts on the entry leaving stage 1; an empty stage 1 makes it harmless.
        if (kill_en) begin
            stage_d[2].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign done     = stage_q[LATENCY];
    assign is_load  = done.valid && (done.op == MEM_OP_LOAD);
    assign is_store = done.valid && (done.op == MEM_OP_STORE);

    // Completions are one per edge, so a load always sees every earlier store already in the array.
    lsu_data_ram #(
        .XLEN  (XLEN),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (is_store),
        .addr_i  (done.addr[AW+1:2]),
        .wdata_i (XLEN'(done.data)),
        .rdata_o (ram_rdata)
    );

    logic unused_addr_bits;
    assign unused_addr_bits = ^{done.addr[1:0], done.addr[LSU_XLEN-1:AW+2]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_vld_q   <= 1'b0;
            st_vld_q   <= 1'b0;
            ld_tag_q   <= '0;
            st_tag_q   <= '0;
            cdb_data_q <= '0;
        end else begin
            ld_vld_q   <= is_load;
            st_vld_q   <= is_store;
            ld_tag_q   <= is_load  ? ROB_TAG_WIDTH'(done.tag) : '0;
            st_tag_q   <= is_store ? ROB_TAG_WIDTH'(done.tag) : '0;
            cdb_data_q <= is_load  ? ram_rdata : '0;
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int i = 1; i <= LATENCY; i++) begin
            inflight_d = inflight_d + 4'(stage_q[i].valid);
        end
    end

    assign inflight_count          = inflight_d;
    assign load_succeeded          = ld_vld_q;
    assign load_succeeded_rob_tag  = ld_tag_q;
    assign store_succeeded         = st_vld_q;
    assign store_succeeded_rob_tag = st_tag_q;
    assign cdb_active              = ld_vld_q;
    assign cdb_data                = cdb_data_q;
    assign cdb_tag                 = ld_tag_q;

endmodule

// File: tb/tb_lsu_memory_responder.sv
// Scoreboard bench for lsu_memory_responder: directed requests push expected responses, a negedge monitor checks them.
module tb_lsu_memory_responder;

    localparam int LAT = 2;
`ifdef LSU_MEM_KILL_EN
    localparam bit KILL_EN = 1'b1;
`else
    localparam bit KILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fire_memory_op = 1'b0;
    logic        memory_op_type = 1'b0;
    logic [31:0] memory_address = '0;
    logic [31:0] memory_data = '0;
    logic [31:0] memory_rob_tag = '0;
    logic        kill_mem_req = 1'b0;
    logic        load_succeeded;
    logic [31:0] load_succeeded_rob_tag;
    logic        store_succeeded;
    logic [31:0] store_succeeded_rob_tag;
    logic        cdb_active;
    logic [31:0] cdb_data;
    logic [31:0] cdb_tag;
    logic [3:0]  inflight_count;

    lsu_memory_responder #(
        .XLEN          (32),
        .ROB_TAG_WIDTH (32),
        .MEM_DEPTH     (1024),
        .LATENCY       (LAT)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .fire_memory_op          (fire_memory_op),
        .memory_op_type          (memory_op_type),
        .memory_address          (memory_address),
        .memory_data             (memory_data),
        .memory_rob_tag          (memory_rob_tag),
        .kill_mem_req            (kill_mem_req),
        .load_succeeded          (load_succeeded),
        .load_succeeded_rob_tag  (load_succeeded_rob_tag),
        .store_succeeded         (store_succeeded),
        .store_succeeded_rob_tag (store_succeeded_rob_tag),
        .cdb_active              (cdb_active),
        .cdb_data                (cdb_data),
        .cdb_tag                 (cdb_tag),
        .inflight_count          (inflight_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] tag;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per response cycle; idle cycles must show all-zero outputs.
    initial begin
        exp_t        e;
        logic [130:0] got_v, exp_v;
        forever begin
            @(negedge clk);
            got_v = {load_succeeded, store_succeeded, cdb_active, load_succeeded_rob_tag,
                     store_succeeded_rob_tag, cdb_tag, cdb_data};
            if (load_succeeded || store_succeeded || cdb_active) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp cyc=%0d got=%h", cyc, got_v);
                end else begin
                    e = sb.pop_front();
                    if (e.op)
                        exp_v = {1'b0, 1'b1, 1'b0, 32'h0, e.tag, 32'h0, 32'h0};
                    else
                        exp_v = {1'b1, 1'b0, 1'b1, e.tag, 32'h0, e.tag, e.data};
                    if (got_v !== exp_v || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL resp tag=%0d cyc=%0d due=%0d got=%h exp=%h",
                                 e.tag, cyc, e.due, got_v, exp_v);
                    end
                end
            end else begin
                n_cmp++;
                if (got_v !== '0) begin
                    n_bad++;
                    $display("FAIL idle_nonzero cyc=%0d got=%h exp=0", cyc, got_v);
                end
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_resp tag=%0d cyc=%0d got=none exp=due %0d",
                             sb[0].tag, cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] tag, input logic kill, input logic exp_resp,
                         input logic [31:0] exp_data);
        exp_t e;
        @(posedge clk); #1;
        fire_memory_op = 1'b1;
        memory_op_type = op;
        memory_address = addr;
        memory_data    = data;
        memory_rob_tag = tag;
        kill_mem_req   = kill;
        if (exp_resp) begin
            e.op   = op;
            e.tag  = tag;
            e.data = exp_data;
            e.due  = cyc + 1 + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic kill);
        @(posedge clk); #1;
        fire_memory_op = 1'b0;
        memory_op_type = 1'b0;
        memory_address = '0;
        memory_data    = '0;
        memory_rob_tag = '0;
        kill_mem_req   = kill;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) idle(1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_inflight", {28'h0, inflight_count}, 32'h0);
        chk("reset_ld", {31'h0, load_succeeded}, 32'h0);
        chk("reset_st", {31'h0, store_succeeded}, 32'h0);
        @(posedge clk); #2;
        reset = 1'b1;

        // Store then load of the same word.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b1, 32'h0);
        idle(1'b0);
        chk("inflight_one", {28'h0, inflight_count}, 32'h1);
        idles(3);
        issue(1'b0, 32'h10, 32'h0, 32'd4, 1'b0, 1'b1, 32'hDEAD_BEEF);
        idles(3);

        // Back-to-back store/load to 0x20.
        issue(1'b1, 32'h20, 32'h1234, 32'd5, 1'b0, 1'b1, 32'h0);
        issue(1'b0, 32'h20, 32'h0, 32'd6, 1'b0, 1'b1, 32'h1234);
        idle(1'b0);
        chk("inflight_two", {28'h0, inflight_count}, 32'h2);
        idles(3);

        // Squash of a store; the load arriving alongside the kill is unaffected.
        issue(1'b1, 32'h30, 32'h11, 32'd6, 1'b0, 1'b1, 32'h0);
        idles(3);
        issue(1'b1, 32'h30, 32'h55, 32'd7, 1'b0, !KILL_EN, 32'h0);
        issue(1'b0, 32'h30, 32'h0, 32'd8, 1'b1, 1'b1, KILL_EN ? 32'h11 : 32'h55);
        idles(4);

        // Kill while stage 1 is empty must not touch the completing store.
        issue(1'b1, 32'h50, 32'h66, 32'd16, 1'b0, 1'b1, 32'h0);
        idle(1'b0);
        idle(1'b1);
        idles(3);
        issue(1'b0, 32'h50, 32'h0, 32'd17, 1'b0, 1'b1, 32'h66);
        idles(3);

        // Address aliasing: 0x1010 wraps onto word 4; low byte bits are ignored.
        issue(1'b1, 32'h1010, 32'hCAFE_F00D, 32'd9, 1'b0, 1'b1, 32'h0);
        issue(1'b0, 32'h10, 32'h0, 32'd10, 1'b0, 1'b1, 32'hCAFE_F00D);
        issue(1'b0, 32'h13, 32'h0, 32'd18, 1'b0, 1'b1, 32'hCAFE_F00D);
        idles(4);

        // Reset with two requests in flight and a response on the outputs.
        issue(1'b1, 32'h40, 32'hAAAA, 32'd11, 1'b0, 1'b1, 32'h0);
        idles(3);
        issue(1'b1, 32'h44, 32'h77, 32'd14, 1'b0, 1'b0, 32'h0);
        issue(1'b1, 32'h40, 32'hBBBB, 32'd12, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 32'h40, 32'h0, 32'd13, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        chk("pre_rst_inflight", {28'h0, inflight_count}, 32'h2);
        chk("pre_rst_st", {31'h0, store_succeeded}, 32'h1);
        chk("pre_rst_st_tag", store_succeeded_rob_tag, 32'd14);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("rst_inflight", {28'h0, inflight_count}, 32'h0);
        chk("rst_st", {31'h0, store_succeeded}, 32'h0);
        chk("rst_st_tag", store_succeeded_rob_tag, 32'h0);
        chk("rst_ld", {31'h0, load_succeeded}, 32'h0);
        chk("rst_cdb", {31'h0, cdb_active}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        idles(6);
        issue(1'b0, 32'h40, 32'h0, 32'd15, 1'b0, 1'b1, 32'hAAAA);
        issue(1'b0, 32'h44, 32'h0, 32'd19, 1'b0, 1'b1, 32'h77);
        idle(1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
        end
        idles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
